lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Multi-cycle load/store controller placed between the register-file read ports and the register-file write port.
- Takes base address (RD1), store data (RD2), an immediate offset and a destination register.
- Runs a request/grant/response handshake with data memory.
- For loads, returns one aligned, sign- or zero-extended write to the register file (WE3/A3/WD3); holds busy so the core stalls while in flight.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for mem_rvalid after grant before aborting with err (1..255)

Ports:
clk  input  1  clock, rising edge
rst_l  input  1  asynchronous active-low reset
start  input  1  launch memory op; sampled only in IDLE
is_store  input  1  1 = store, 0 = load
funct3  input  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
base  input  32  base address (from RD1)
offset  input  32  sign-extended immediate
store_data  input  32  store data (from RD2)
rd  input  5  load destination register
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
rf_we  output  1  register-file write enable (to WE3)
rf_waddr  output  5  write address (to A3)
rf_wdata  output  32  write data (to WD3)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (async, rst_l=0): state IDLE, all outputs 0, timeout counter 0. Reset mid-operation aborts immediately: mem_req drops combinationally with reset, no rf write, no done.
- States: IDLE, REQ, WAIT, FIN.
- IDLE:
  - On start=1, latch is_store, funct3, rd, store_data, and addr = base+offset (mod 2^32, carry discarded).
  - If funct3 is illegal (011, 110, 111; or 100/101 with is_store=1) or the access is misaligned (H with addr[0]=1, W with addr[1:0]!=0), go to FIN with err. No bus activity in that case.
  - Otherwise go to REQ.
- REQ: mem_req=1, mem_we=is_store, mem_addr/mem_be/mem_wdata stable until mem_gnt.
  - On mem_gnt: store -> FIN; load -> WAIT with counter cleared.
  - mem_rvalid is ignored in REQ.
- WAIT: mem_req=0. Counter increments each cycle.
  - On mem_rvalid: extract the lane, extend, go to FIN with the write staged.
  - If the counter reaches TIMEOUT_CYCLES with no rvalid: FIN with err, no write.
- FIN (exactly one cycle): done=1, err as staged; rf_we=1 only for a successful load with rd!=0. Next state IDLE. start is not accepted in FIN.
- Byte enables / store data:
  - B: be = 1<<addr[1:0], wdata = {4{sd[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - W: be = 1111, wdata = sd.
- Load extraction: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]). B/H sign-extend, BU/HU zero-extend, W passes through.
- rf_waddr/rf_wdata hold their last values outside FIN and are qualified only by rf_we.
- Latency from start (cycle 0), zero-wait memory: REQ at cycle 1. Load with gnt@1 and rvalid@2 gives FIN@3. Store with gnt@1 gives FIN@2. Error path gives FIN@1.
- start while busy is ignored; no queueing.

Test Plan:
- LW: base=0x40, offset=0, mem_rdata=0xDEADBEEF, gnt@1, rvalid@2 -> mem_addr=0x40, be=1111 at cycle 1; cycle 3 rf_we=1, rf_waddr=rd, rf_wdata=0xDEADBEEF, done=1.
- LB/LBU: addr=0x43, rdata=0x80FFFFFF -> LB writes 0xFFFFFF80; LBU writes 0x00000080.
- SH: base=0x40, offset=2, store_data=0x00001234, gnt delayed to cycle 4 -> mem_req held cycles 1-4 with addr=0x40, be=1100, wdata=0x12341234; done@5, rf_we=0.
- Misaligned LW at 0x41, and funct3=011 -> mem_req never asserts; done=err=1 at cycle 1; no write.
- TIMEOUT_CYCLES=4, load granted but no rvalid -> FIN with err after 4 WAIT cycles; rvalid arriving later is ignored. LW to rd=0 -> done, rf_we stays 0.
- Reset: rst_l low during WAIT -> mem_req/busy 0 immediately, no done. After release, a new start completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: request/grant/response handshake with data
// memory, byte-lane steering for stores, lane extraction and extension for loads,
// and a single register-file write per completed load.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t          state;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [1:0]      addr_lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] addr_c;
    logic        bad_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] byte_sh_c;
    logic [31:0] half_sh_c;
    logic [31:0] load_val_c;

    // Effective address, legality/alignment check and store lane steering
    always_comb begin
        addr_c  = base + offset;
        bad_c   = 1'b0;
        be_c    = 4'b0000;
        wdata_c = store_data;
        case (funct3)
            3'b000, 3'b100: begin
                be_c    = 4'(4'b0001 << addr_c[1:0]);
                wdata_c = {4{store_data[7:0]}};
                bad_c   = is_store & funct3[2];
            end
            3'b001, 3'b101: begin
                be_c    = addr_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
                bad_c   = addr_c[0] | (is_store & funct3[2]);
            end
            3'b010: begin
                be_c    = 4'b1111;
                bad_c   = (addr_c[1:0] != 2'b00);
            end
            default: bad_c = 1'b1;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        byte_sh_c  = mem_rdata >> {addr_lo_q, 3'b000};
        half_sh_c  = mem_rdata >> {addr_lo_q[1], 4'b0000};
        load_val_c = mem_rdata;
        case (funct3_q)
            3'b000:  load_val_c = {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
            3'b001:  load_val_c = {{16{half_sh_c[15]}}, half_sh_c[15:0]};
            3'b100:  load_val_c = {24'h0, byte_sh_c[7:0]};
            3'b101:  load_val_c = {16'h0, half_sh_c[15:0]};
            default: load_val_c = mem_rdata;
        endcase
    end

    // Control FSM with registered bus, register-file and status outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            addr_lo_q  <= 2'b00;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        rd_q       <= rd;
                        addr_lo_q  <= addr_c[1:0];
                        busy       <= 1'b1;
                        if (bad_c) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr_c[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_store_q) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt_q <= '0;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid) begin
                        state <= FIN;
                        done  <= 1'b1;
                        if (rd_q != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd_q;
                            rf_wdata <= load_val_c;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
